// File: rtl/cflog_pkg.sv
// Shared definitions for the control-flow log controller: entry layout,
// FSM state encoding and the entry packing helper.
package cflog_pkg;

    localparam int ENTRY_W = 37;
    localparam int DST_LSB = 0;
    localparam int SRC_LSB = 16;
    localparam int FLG_LSB = 32;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RD_ISSUE   = 2'd1,
        ST_RD_CAPTURE = 2'd2,
        ST_CLEAR      = 2'd3
    } cflog_state_e;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [4:0]  flags,
                                                      input logic [15:0] src,
                                                      input logic [15:0] dst);
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[FLG_LSB +: 5]  = flags;
        e[SRC_LSB +: 16] = src;
        e[DST_LSB +: 16] = dst;
        return e;
    endfunction

endpackage

// File: rtl/cflog_ctrl.sv
// Control-flow log controller: stages trace events into a no-wrap circular log
// RAM and drains it oldest-first through a three-state read sequence.
module cflog_ctrl
    import cflog_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 37,
    parameter int LOG_DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  evt_valid,
    input  logic [15:0]           evt_src,
    input  logic [15:0]           evt_dst,
    input  logic [4:0]            evt_flags,
    input  logic                  clr_req,
    input  logic                  rd_req,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_entry,
    output logic [ADDR_WIDTH:0]   log_count,
    output logic                  log_empty,
    output logic                  log_full,
    output logic                  overflow,
    output logic                  busy,
    output logic                  ram_clr,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [1:0]            dbg_state_o
);

    localparam int CW = ADDR_WIDTH + 1;

    // Handshake: evt_valid is a one-cycle strobe with no back-pressure (drops are
    // flagged by overflow); rd_req is a level, each accepted pop answers with a
    // one-cycle rd_valid pulse and rd_entry holds until the next pop.
    cflog_state_e          state_q;
    logic [ADDR_WIDTH-1:0] head_q, tail_q;
    logic [CW-1:0]         count_q;
    logic                  stage_vld_q;
    logic [DATA_WIDTH-1:0] stage_entry_q;
    logic [ADDR_WIDTH-1:0] stage_addr_q;
    logic                  ovf_q;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_entry_q;

    logic stage_we, pop, full_eff, evt_accept, evt_drop;

    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
        return (p == ADDR_WIDTH'(LOG_DEPTH - 1)) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    assign stage_we = stage_vld_q && (state_q != ST_RD_CAPTURE);
    assign pop      = (state_q == ST_RD_CAPTURE);
    // The in-flight stage write already owns a slot, so it counts against capacity.
    assign full_eff   = (count_q + CW'(stage_we)) >= CW'(LOG_DEPTH);
    assign evt_accept = evt_valid && (!stage_vld_q || stage_we) && !full_eff;
    assign evt_drop   = evt_valid && !evt_accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            stage_vld_q   <= 1'b0;
            stage_entry_q <= '0;
            stage_addr_q  <= '0;
            ovf_q         <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_entry_q    <= '0;
        end else if (clr_req) begin
            state_q     <= ST_CLEAR;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            stage_vld_q <= 1'b0;
            ovf_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (stage_we) begin
                tail_q <= next_ptr(tail_q);
            end
            case ({stage_we, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (evt_accept) begin
                stage_vld_q   <= 1'b1;
                stage_entry_q <= pack_entry(evt_flags, evt_src, evt_dst);
                stage_addr_q  <= stage_we ? next_ptr(tail_q) : tail_q;
            end else if (stage_we) begin
                stage_vld_q <= 1'b0;
            end
            if (evt_drop) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (rd_req && (count_q != '0)) begin
                        state_q <= ST_RD_ISSUE;
                    end
                end
                ST_RD_ISSUE: begin
                    // A concurrent stage write wins the RAM port; retry the read.
                    if (!stage_we) begin
                        state_q <= ST_RD_CAPTURE;
                    end
                end
                ST_RD_CAPTURE: begin
                    rd_entry_q <= ram_rd_data;
                    head_q     <= next_ptr(head_q);
                    rd_valid_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_valid    = rd_valid_q;
    assign rd_entry    = rd_entry_q;
    assign log_count   = count_q;
    assign log_empty   = (count_q == '0);
    assign log_full    = (count_q == CW'(LOG_DEPTH));
    assign overflow    = ovf_q;
    assign busy        = (state_q != ST_IDLE) || stage_vld_q;
    assign ram_clr     = (state_q == ST_CLEAR);
    assign ram_we      = stage_we;
    assign ram_wr_addr = stage_addr_q;
    assign ram_wr_data = stage_entry_q;
    assign ram_re      = (state_q == ST_RD_ISSUE) || (state_q == ST_RD_CAPTURE);
    assign ram_rd_addr = head_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cflog_ctrl.sv
// Bench for cflog_ctrl: log RAM model, queue-based reference of the log,
// per-cycle output compare, directed scenarios and a randomized phase.
module tb_cflog_ctrl;

    localparam int A     = 8;
    localparam int W     = 37;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, evt_valid, clr_req, rd_req;
    logic [15:0]   evt_src, evt_dst;
    logic [4:0]    evt_flags;
    logic          rd_valid, log_empty, log_full, overflow, busy;
    logic [W-1:0]  rd_entry, ram_wr_data, ram_rd_data;
    logic [A:0]    log_count;
    logic          ram_clr, ram_we, ram_re;
    logic [A-1:0]  ram_wr_addr, ram_rd_addr;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;

    // Reference model: the log is a plain queue of committed entries.
    logic [W-1:0] exp_q[$];
    bit           m_ready = 0;
    bit           m_stage = 0;
    logic [W-1:0] m_stage_e = '0;
    int           m_phase = 0;   // 0 idle, 1 read issued, 2 read capture, 3 clear
    int           m_wr = 0, m_rd = 0;
    bit           m_ovf = 0, m_rdv = 0;
    logic [W-1:0] m_rde = '0;
    logic [A-1:0] wr_addr_log[$];

    cflog_ctrl #(.ADDR_WIDTH(A), .DATA_WIDTH(W), .LOG_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .evt_valid(evt_valid), .evt_src(evt_src), .evt_dst(evt_dst), .evt_flags(evt_flags),
        .clr_req(clr_req), .rd_req(rd_req),
        .rd_valid(rd_valid), .rd_entry(rd_entry), .log_count(log_count),
        .log_empty(log_empty), .log_full(log_full), .overflow(overflow), .busy(busy),
        .ram_clr(ram_clr), .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_re(ram_re), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .dbg_state_o(dbg_state)
    );

    // Log RAM: write has priority; a read that collides with a write returns junk.
    logic [W-1:0] mem [0:255];
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_re && !ram_we) ram_rd_data <= mem[ram_rd_addr];
        else                   ram_rd_data <= 37'({$urandom(), $urandom()});
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model update on every edge from the inputs alone.
    initial begin
        int  sz0;
        bit  we, pop, acc;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_q.delete();
                m_phase = 0; m_wr = 0; m_rd = 0; m_stage = 0;
                m_ovf = 0; m_rdv = 0; m_rde = '0; m_ready = 1;
            end else if (clr_req) begin
                exp_q.delete();
                m_phase = 3; m_wr = 0; m_rd = 0; m_stage = 0; m_ovf = 0; m_rdv = 0;
            end else begin
                sz0 = exp_q.size();
                we  = m_stage && (m_phase != 2);
                pop = (m_phase == 2);
                acc = evt_valid && (!m_stage || we) && ((sz0 + (we ? 1 : 0)) < DEPTH);
                if (evt_valid && !acc) m_ovf = 1;
                m_rdv = 0;
                if (we) begin
                    exp_q.push_back(m_stage_e);
                    m_wr++;
                end
                if (pop) begin
                    m_rde = exp_q.pop_front();
                    m_rdv = 1;
                    m_rd++;
                end
                if (acc) begin
                    m_stage   = 1;
                    m_stage_e = {evt_flags, evt_src, evt_dst};
                end else if (we) begin
                    m_stage = 0;
                end
                case (m_phase)
                    0:       if (rd_req && sz0 > 0) m_phase = 1;
                    1:       if (!we) m_phase = 2;
                    default: m_phase = 0;
                endcase
            end
        end
    end

    // Per-cycle compare against the model, mid-cycle.
    initial begin
        bit exp_we;
        forever begin
            @(negedge clk);
            if (m_ready && rst_n) begin
                exp_we = m_stage && (m_phase != 2);
                chk("ram_we",    64'(ram_we),    64'(exp_we));
                chk("ram_re",    64'(ram_re),    64'(m_phase == 1 || m_phase == 2));
                chk("ram_clr",   64'(ram_clr),   64'(m_phase == 3));
                chk("log_count", 64'(log_count), 64'(exp_q.size()));
                chk("log_empty", 64'(log_empty), 64'(exp_q.size() == 0));
                chk("log_full",  64'(log_full),  64'(exp_q.size() == DEPTH));
                chk("overflow",  64'(overflow),  64'(m_ovf));
                chk("busy",      64'(busy),      64'(m_phase != 0 || m_stage));
                chk("rd_valid",  64'(rd_valid),  64'(m_rdv));
                chk("rd_entry",  64'(rd_entry),  64'(m_rde));
                if (exp_we) begin
                    chk("wr_addr", 64'(ram_wr_addr), 64'(m_wr % DEPTH));
                    chk("wr_data", 64'(ram_wr_data), 64'(m_stage_e));
                end
                if (m_phase == 1 || m_phase == 2)
                    chk("rd_addr", 64'(ram_rd_addr), 64'(m_rd % DEPTH));
                if (ram_we) wr_addr_log.push_back(ram_wr_addr);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_evt(input logic [15:0] s, input logic [15:0] d, input logic [4:0] f);
        evt_valid = 1'b1; evt_src = s; evt_dst = d; evt_flags = f;
        step();
        evt_valid = 1'b0;
    endtask

    task automatic wait_rdv(output bit got, output logic [W-1:0] e);
        got = 0;
        e   = '0;
        for (int k = 0; k < 12; k++) begin
            if (rd_valid) begin
                got = 1;
                e   = rd_entry;
                break;
            end
            step();
        end
    endtask

    task automatic pop_one(output bit got, output logic [W-1:0] e);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        wait_rdv(got, e);
    endtask

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        bit           got, seen;
        logic [W-1:0] e, lit;
        int           n0, n;

        rst_n = 1'b0; evt_valid = 1'b0; clr_req = 1'b0; rd_req = 1'b0;
        evt_src = '0; evt_dst = '0; evt_flags = '0;
        repeat (3) step();
        chk("rst_count",   64'(log_count), 64'(0));
        chk("rst_empty",   64'(log_empty), 64'(1));
        chk("rst_rdvalid", 64'(rd_valid),  64'(0));
        chk("rst_rdentry", 64'(rd_entry),  64'(0));
        chk("rst_strobes", 64'({ram_we, ram_re, ram_clr}), 64'(0));
        chk("rst_ovf",     64'(overflow),  64'(0));
        rst_n = 1'b1;
        step();

        // Three back-to-back events land at addresses 0,1,2.
        n0 = wr_addr_log.size();
        for (int i = 0; i < 3; i++) send_evt(16'h1000 + 16'(2 * i), 16'h2000 + 16'(i), 5'(i + 1));
        repeat (3) step();
        chk("three_count", 64'(log_count), 64'(3));
        chk("three_addr0", 64'(wr_addr_log[n0]),     64'(0));
        chk("three_addr2", 64'(wr_addr_log[n0 + 2]), 64'(2));

        for (int i = 0; i < 3; i++) begin
            pop_one(got, e);
            lit = {5'(i + 1), 16'h1000 + 16'(2 * i), 16'h2000 + 16'(i)};
            chk("drain_valid", 64'(got), 64'(1));
            chk("drain_entry", 64'(e), 64'(lit));
        end
        step();
        chk("drain_empty", 64'(log_empty), 64'(1));
        pop_one(got, e);
        chk("empty_pop_ignored", 64'(got), 64'(0));

        // Fill to capacity then one extra event.
        n0 = wr_addr_log.size();
        for (int i = 0; i < DEPTH + 1; i++)
            send_evt(16'($urandom), 16'($urandom), 5'($urandom));
        repeat (3) step();
        chk("fill_full",   64'(log_full),  64'(1));
        chk("fill_ovf",    64'(overflow),  64'(1));
        chk("fill_count",  64'(log_count), 64'(DEPTH));
        chk("fill_writes", 64'(wr_addr_log.size() - n0), 64'(DEPTH));

        // Clear lands while a read is in its capture cycle, with a coincident event.
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        step();
        chk("capture_state", 64'(dbg_state), 64'(2));
        clr_req = 1'b1; evt_valid = 1'b1; evt_src = 16'hdead; evt_dst = 16'hbeef;
        step();
        clr_req = 1'b0; evt_valid = 1'b0;
        chk("clr_strobe", 64'(ram_clr),   64'(1));
        chk("clr_count",  64'(log_count), 64'(0));
        chk("clr_ovf",    64'(overflow),  64'(0));
        step();
        chk("clr_one_cycle", 64'(ram_clr), 64'(0));
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (rd_valid) seen = 1;
            step();
        end
        chk("clr_no_rdvalid", 64'(seen), 64'(0));
        chk("clr_idle", 64'(busy), 64'(0));

        // Event staged on the same edge the read issues: issue is voided once.
        send_evt(16'h3000, 16'h3100, 5'h02);
        send_evt(16'h3002, 16'h3102, 5'h03);
        repeat (3) step();
        rd_req = 1'b1; evt_valid = 1'b1; evt_src = 16'h3004; evt_dst = 16'h3104; evt_flags = 5'h04;
        step();
        rd_req = 1'b0; evt_valid = 1'b0;
        chk("void_issue", 64'({ram_we, ram_re}), 64'(3));
        wait_rdv(got, e);
        lit = {5'h02, 16'h3000, 16'h3100};
        chk("void_valid", 64'(got), 64'(1));
        chk("void_entry", 64'(e), 64'(lit));
        repeat (2) step();
        chk("void_count", 64'(log_count), 64'(2));

        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (2) step();

        // 64 writes, 64 pops, then two more events wrap to addresses 0,1.
        for (int i = 0; i < DEPTH; i++)
            send_evt(16'($urandom), 16'($urandom), 5'($urandom));
        repeat (2) step();
        for (int i = 0; i < DEPTH; i++) begin
            pop_one(got, e);
            chk("wrap_pop_valid", 64'(got), 64'(1));
        end
        send_evt(16'h5000, 16'h5100, 5'h11);
        send_evt(16'h5002, 16'h5102, 5'h12);
        repeat (3) step();
        n = wr_addr_log.size();
        chk("wrap_addr0", 64'(wr_addr_log[n - 2]), 64'(0));
        chk("wrap_addr1", 64'(wr_addr_log[n - 1]), 64'(1));
        pop_one(got, e);
        lit = {5'h11, 16'h5000, 16'h5100};
        chk("wrap_entry0", 64'(e), 64'(lit));
        pop_one(got, e);
        lit = {5'h12, 16'h5002, 16'h5102};
        chk("wrap_entry1", 64'(e), 64'(lit));

        // Randomized traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            evt_valid = ($urandom_range(0, 99) < 45);
            evt_src   = 16'($urandom);
            evt_dst   = 16'($urandom);
            evt_flags = 5'($urandom);
            rd_req    = ($urandom_range(0, 99) < 35);
            clr_req   = ($urandom_range(0, 299) == 0);
            step();
        end
        evt_valid = 1'b0; rd_req = 1'b0; clr_req = 1'b0;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
